calc_key_sequencer: RTL and testbench
=====================================

CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), the number of consecutive stable cycles needed to accept a key level change.
REQ-002 SHALL have port CLOCK_50  in  1  the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port key_n  in  3  raw pushbuttons, active-low; [0]=enter, [1]=op_next, [2]=clear.
REQ-005 SHALL have port sw  in  8  operand switches; [7:4]=A, [3:0]=B.
REQ-006 SHALL have port calc_r  in  4  signed result returned by the downstream combinational calculator.
REQ-007 SHALL have port calc_ovf  in  1  overflow flag returned by the downstream calculator.
REQ-008 SHALL have port calc_op  out  3  registered opcode driven to the calculator.
REQ-009 SHALL have ports calc_a and calc_b  out  4 each  registered operands driven to the calculator.
REQ-010 SHALL have ports res (out, 4) and res_ovf (out, 1): the latched result and overflow for display.
REQ-011 SHALL have port res_valid  out  1  high while res/res_ovf hold a completed result.
REQ-012 SHALL have port busy  out  1  high in states EXEC and LATCH.

Function
REQ-013 SHALL pass each key_n bit through a 2-flop synchronizer before debouncing.
REQ-014 SHALL update a key's debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
REQ-015 SHALL emit a one-cycle press pulse per key when its debounced level goes 1->0; release emits nothing.
REQ-016 SHALL implement FSM states IDLE, EXEC, LATCH, SHOW.
REQ-017 SHALL give simultaneous pulses the priority clear > enter > op_next; lower-priority pulses in the same cycle are discarded.
REQ-018 On clear in any state: state->IDLE; calc_op, calc_a, calc_b, res, res_ovf and res_valid all ->0.
REQ-019 On enter in IDLE or SHOW: calc_a<=sw[7:4], calc_b<=sw[3:0], res_valid<=0, state->EXEC.
REQ-020 SHALL ignore enter and op_next in EXEC and LATCH.
REQ-021 On op_next in IDLE or SHOW: calc_op<=calc_op+1 modulo 8 (7 wraps to 0); res_valid<=0, state->IDLE.
REQ-022 EXEC SHALL last exactly one cycle with operands stable, then go to LATCH.
REQ-023 LATCH SHALL capture calc_r into res and calc_ovf into res_ovf, set res_valid, and go to SHOW.
REQ-024 Latency: for an enter pulse at cycle N, EXEC is at N+1, LATCH at N+2, and res_valid is high from N+3.
REQ-025 SHOW SHALL hold res, res_ovf and res_valid until the next clear, enter or op_next.
REQ-026 calc_op, calc_a and calc_b SHALL change only on the clock edges named in REQ-018, REQ-019 and REQ-021.

Reset
REQ-027 reset_n low SHALL asynchronously force: state=IDLE; all outputs 0; synchronizer flops and debounced levels 1 (released); debounce counters 0.
REQ-028 Reset asserted mid-operation (EXEC/LATCH) SHALL discard the operation; no res_valid follows the deassertion.
REQ-029 A key already held low at reset deassertion SHALL produce exactly one press pulse, after DEBOUNCE_CYCLES plus synchronizer delay.

Structure
REQ-030 Package calc_pkg SHALL hold the FSM state enumeration, operand width (4), opcode width (3) and the DEBOUNCE_CYCLES default.
REQ-031 SHALL instantiate one sub-module key_debounce per key (synchronizer, counter, press pulse), parameterized by DEBOUNCE_CYCLES.
REQ-032 The debounce counter width SHALL be derived from DEBOUNCE_CYCLES (clog2), not hard-coded.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Bounce: key_n[0] low for 2 cycles then high, then low for 10 cycles -> exactly one enter pulse, and no action from the first glitch.
REQ-034 Compute: sw=8'h3A, enter, model returns calc_r=4'hD, calc_ovf=0 -> calc_a=3, calc_b=A, res=D, res_ovf=0, res_valid first high at N+3, busy high at N+1..N+2.
REQ-035 Op wrap: from reset, 8 op_next presses -> calc_op steps 1..7 then 0.
REQ-036 Overflow: model returns calc_ovf=1, calc_r=4'h8 -> res=8, res_ovf=1, held in SHOW across 100 idle cycles.
REQ-037 Simultaneous: clear and enter pulses in the same cycle while in SHOW -> IDLE, all outputs 0; enter pulse during EXEC -> ignored, and calc_a/calc_b stay unchanged.
REQ-038 Reset mid-op: reset_n low during LATCH -> outputs 0 immediately (asynchronously), IDLE after release, and res_valid stays 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer.
//   - FSM state enumeration
//   - operand / opcode widths
//   - default debounce length (10 ms at 50 MHz)
//   - key index assignments within key_n
package calc_pkg;

    localparam int OPND_W           = 4;
    localparam int OP_W             = 3;
    localparam int DEBOUNCE_DEFAULT = 500000;

    localparam int NUM_KEYS   = 3;
    localparam int KEY_ENTER  = 0;
    localparam int KEY_OPNEXT = 1;
    localparam int KEY_CLEAR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_LATCH = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer, stability counter and
// press-pulse generator for one active-low pushbutton.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   key_n  in  1  raw active-low key
//   press  out 1  one-cycle pulse, high in the first cycle the debounced
//                 level is low (1->0 transition); releases give nothing
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    // The counter only ever holds 0..DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                // Nth consecutive differing cycle: accept the new level.
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    press_reg <= ~sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                // Any return to the accepted level restarts the count.
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/calc_key_sequencer.sv
// Pushbutton front end for a combinational 4-bit calculator. Debounces
// three keys and sequences operand/opcode loading and result capture.
// Ports:
//   CLOCK_50  in  1  clock
//   reset_n   in  1  asynchronous active-low reset
//   key_n     in  3  raw keys, active-low: [0]=enter [1]=op_next [2]=clear
//   sw        in  8  operands: [7:4]=A, [3:0]=B
//   calc_r    in  4  result from the calculator
//   calc_ovf  in  1  overflow from the calculator
//   calc_op   out 3  registered opcode to the calculator
//   calc_a    out 4  registered operand A
//   calc_b    out 4  registered operand B
//   res       out 4  latched result for display
//   res_ovf   out 1  latched overflow for display
//   res_valid out 1  res/res_ovf hold a completed result
//   busy      out 1  operation in flight (EXEC or LATCH)
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [2:0]        key_n,
    input  logic [7:0]        sw,
    input  logic [OPND_W-1:0] calc_r,
    input  logic              calc_ovf,
    output logic [OP_W-1:0]   calc_op,
    output logic [OPND_W-1:0] calc_a,
    output logic [OPND_W-1:0] calc_b,
    output logic [OPND_W-1:0] res,
    output logic              res_ovf,
    output logic              res_valid,
    output logic              busy
);

    logic [NUM_KEYS-1:0] press;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk   (CLOCK_50),
                .rst_n (reset_n),
                .key_n (key_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [OP_W-1:0]   op_reg, op_next;
    logic [OPND_W-1:0] a_reg, a_next;
    logic [OPND_W-1:0] b_reg, b_next;
    logic [OPND_W-1:0] res_reg, res_next;
    logic              ovf_reg, ovf_next;
    logic              valid_reg, valid_next;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            ovf_reg   <= ovf_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        ovf_next   = ovf_reg;
        valid_next = valid_reg;

        // Clear wins over everything, in every state.
        if (press[KEY_CLEAR]) begin
            state_next = ST_IDLE;
            op_next    = '0;
            a_next     = '0;
            b_next     = '0;
            res_next   = '0;
            ovf_next   = 1'b0;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_SHOW: begin
                    if (press[KEY_ENTER]) begin
                        a_next     = sw[7:4];
                        b_next     = sw[3:0];
                        valid_next = 1'b0;
                        state_next = ST_EXEC;
                    end else if (press[KEY_OPNEXT]) begin
                        op_next    = OP_W'(op_reg + 1'b1);
                        valid_next = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
                // Operands are held for one full cycle so the calculator settles.
                ST_EXEC: state_next = ST_LATCH;
                ST_LATCH: begin
                    res_next   = calc_r;
                    ovf_next   = calc_ovf;
                    valid_next = 1'b1;
                    state_next = ST_SHOW;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign calc_op   = op_reg;
    assign calc_a    = a_reg;
    assign calc_b    = b_reg;
    assign res       = res_reg;
    assign res_ovf   = ovf_reg;
    assign res_valid = valid_reg;
    assign busy      = (state_reg == ST_EXEC) || (state_reg == ST_LATCH);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer with DEBOUNCE_CYCLES=4.
// A stand-in calculator drives calc_r/calc_ovf; a key-level model tracks
// what the outputs should be after each completed key press.
module tb_calc_key_sequencer;

    localparam int DB   = 4;
    localparam int HOLD = 12;   // long enough for sync + debounce + FSM to settle

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic [7:0] sw = 8'h00;
    logic [3:0] calc_r;
    logic       calc_ovf;
    logic [2:0] calc_op;
    logic [3:0] calc_a, calc_b, res;
    logic       res_ovf, res_valid, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in calculator: fixed value when fixed_en, else signed add/sub.
    logic       fixed_en = 1'b0;
    logic [4:0] fixed_val = 5'h00;

    // Key-level reference model.
    logic [2:0] m_op = '0;
    logic [3:0] m_a = '0, m_b = '0, m_res = '0;
    logic       m_ovf = 1'b0, m_valid = 1'b0;

    calc_key_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .key_n    (key_n),
        .sw       (sw),
        .calc_r   (calc_r),
        .calc_ovf (calc_ovf),
        .calc_op  (calc_op),
        .calc_a   (calc_a),
        .calc_b   (calc_b),
        .res      (res),
        .res_ovf  (res_ovf),
        .res_valid(res_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] calc_model(input logic [2:0] op, input logic [3:0] a,
                                              input logic [3:0] b);
        int sa, sb, r;
        logic ovf;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        r   = op[0] ? (sa - sb) : (sa + sb);
        ovf = (r > 7) || (r < -8);
        return {ovf, r[3:0]};
    endfunction

    always_comb begin
        {calc_ovf, calc_r} = fixed_en ? fixed_val : calc_model(calc_op, calc_a, calc_b);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_ovf = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_press(input int k, input logic [7:0] s);
        case (k)
            2: model_reset();
            0: begin
                m_a = s[7:4];
                m_b = s[3:0];
                {m_ovf, m_res} = fixed_en ? fixed_val : calc_model(m_op, m_a, m_b);
                m_valid = 1'b1;
            end
            default: begin
                m_op    = m_op + 3'd1;
                m_valid = 1'b0;
            end
        endcase
    endtask

    task automatic press_key(input int k);
        key_n[k] = 1'b0;
        repeat (HOLD) cyc();
        key_n[k] = 1'b1;
        repeat (HOLD) cyc();
    endtask

    task automatic wait_busy(output int n, output bit found);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (busy) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if ({calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_held outputs=%h required=0",
                     {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy});
        end
        rst_n = 1'b1;
        repeat (3) cyc();
        n_checks++;
        if ({calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_release outputs=%h required=0",
                     {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy});
        end
        model_reset();
        $display("txn reset done");
    endtask

    task automatic test_bounce();
        int busy_cycles = 0, first = 0;
        sw = 8'h52;
        key_n[0] = 1'b0;
        repeat (2) cyc();
        key_n[0] = 1'b1;
        repeat (12) begin
            cyc();
            if (busy) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_glitch busy_cycles=%0d res_valid=%b required 0/0",
                     busy_cycles, res_valid);
        end
        key_n[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (busy) begin
                busy_cycles++;
                if (first == 0) first = i;
            end
        end
        key_n[0] = 1'b1;
        repeat (20) begin
            cyc();
            if (busy) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 2) begin
            n_fail++;
            $display("FAIL bounce_busy_cycles got=%0d required=2", busy_cycles);
        end
        n_checks++;
        if (first < DB + 2 || first > DB + 4) begin
            n_fail++;
            $display("FAIL bounce_latency first_busy=%0d required %0d..%0d", first, DB + 2, DB + 4);
        end
        model_press(0, 8'h52);
        n_checks++;
        if ({calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy}
            !== {m_op, m_a, m_b, m_res, m_ovf, m_valid, 1'b0}) begin
            n_fail++;
            $display("FAIL bounce_result got=%h required=%h",
                     {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy},
                     {m_op, m_a, m_b, m_res, m_ovf, m_valid, 1'b0});
        end
        $display("txn bounce busy_cycles=%0d first_busy=%0d", busy_cycles, first);
    endtask

    task automatic test_compute();
        int n;
        bit found;
        sw = 8'h3A;
        fixed_en = 1'b1;
        fixed_val = 5'h0D;
        key_n[0] = 1'b0;
        wait_busy(n, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL compute_timeout busy never rose");
        end
        // N+1 : EXEC
        n_checks++;
        if ({busy, res_valid, calc_a, calc_b} !== {1'b1, 1'b0, 4'h3, 4'hA}) begin
            n_fail++;
            $display("FAIL compute_exec got busy=%b valid=%b a=%h b=%h required 1 0 3 a",
                     busy, res_valid, calc_a, calc_b);
        end
        cyc();  // N+2 : LATCH
        n_checks++;
        if ({busy, res_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL compute_latch got busy=%b valid=%b required 1 0", busy, res_valid);
        end
        cyc();  // N+3 : SHOW
        n_checks++;
        if ({busy, res_valid, res, res_ovf} !== {1'b0, 1'b1, 4'hD, 1'b0}) begin
            n_fail++;
            $display("FAIL compute_show got busy=%b valid=%b res=%h ovf=%b required 0 1 d 0",
                     busy, res_valid, res, res_ovf);
        end
        key_n[0] = 1'b1;
        repeat (HOLD) cyc();
        model_press(0, 8'h3A);
        fixed_en = 1'b0;
        $display("txn compute sw=3a res=%h ovf=%b", res, res_ovf);
    endtask

    task automatic test_op_wrap();
        logic [2:0] exp_op;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            press_key(1);
            model_press(1, sw);
            exp_op = 3'(i);
            n_checks++;
            if (calc_op !== exp_op || res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL op_wrap press=%0d calc_op=%0d required=%0d valid=%b",
                         i, calc_op, exp_op, res_valid);
            end
            $display("txn op_next %0d calc_op=%0d", i, calc_op);
        end
    endtask

    task automatic test_overflow();
        int held = 0;
        fixed_en = 1'b1;
        fixed_val = {1'b1, 4'h8};
        sw = 8'(($urandom));
        press_key(0);
        model_press(0, sw);
        n_checks++;
        if ({res, res_ovf, res_valid, busy} !== {4'h8, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL overflow_latch res=%h ovf=%b valid=%b busy=%b required 8 1 1 0",
                     res, res_ovf, res_valid, busy);
        end
        fixed_en = 1'b0;  // calculator output moves; latched result must not
        repeat (100) begin
            cyc();
            if ({res, res_ovf, res_valid, busy} === {4'h8, 1'b1, 1'b1, 1'b0}) held++;
        end
        n_checks++;
        if (held != 100) begin
            n_fail++;
            $display("FAIL overflow_hold held=%0d required=100", held);
        end
        $display("txn overflow res=%h ovf=%b held=%0d", res, res_ovf, held);
    endtask

    task automatic test_simultaneous();
        int n, busy_cycles = 0;
        bit found;
        logic [7:0] s;
        // clear + enter together while in SHOW
        key_n = 3'b010;
        repeat (HOLD) begin
            cyc();
            if (busy) busy_cycles++;
        end
        key_n = 3'b111;
        repeat (HOLD) cyc();
        model_press(2, sw);
        n_checks++;
        if ({calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy} !== 18'h0 || busy_cycles != 0) begin
            n_fail++;
            $display("FAIL simul_clear_enter outputs=%h busy_cycles=%0d required 0/0",
                     {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy}, busy_cycles);
        end
        // op_next pulse lands one cycle after enter (during EXEC); sw moves too
        s = 8'hC5;
        sw = s;
        key_n[0] = 1'b0;
        cyc();
        key_n[1] = 1'b0;
        wait_busy(n, found);
        sw = ~s;
        repeat (HOLD) cyc();
        key_n = 3'b111;
        repeat (HOLD) cyc();
        model_press(0, s);
        n_checks++;
        if (!found || {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy}
                      !== {m_op, m_a, m_b, m_res, m_ovf, m_valid, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_exec_ignore found=%b got=%h required=%h", found,
                     {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy},
                     {m_op, m_a, m_b, m_res, m_ovf, m_valid, 1'b0});
        end
        $display("txn simultaneous a=%h b=%h op=%0d", calc_a, calc_b, calc_op);
    endtask

    task automatic test_reset_mid_op();
        int n, bad = 0;
        bit found;
        press_key(1);
        model_press(1, sw);
        sw = 8'h97;
        key_n[0] = 1'b0;
        wait_busy(n, found);
        cyc();  // now in LATCH
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (!found || {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op_async found=%b outputs=%h required=0", found,
                     {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy});
        end
        key_n[0] = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;
        model_reset();
        repeat (2 * HOLD) begin
            cyc();
            if (res_valid || busy) bad++;
        end
        n_checks++;
        if (bad != 0 || {calc_op, calc_a, calc_b, res, res_ovf} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op_after bad_cycles=%0d outputs=%h required 0/0", bad,
                     {calc_op, calc_a, calc_b, res, res_ovf});
        end
        $display("txn reset_mid_op bad_cycles=%0d", bad);
    endtask

    task automatic test_held_at_reset();
        rst_n = 1'b0;
        key_n[1] = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        model_reset();
        repeat (3 * HOLD) cyc();
        key_n[1] = 1'b1;
        repeat (HOLD) cyc();
        model_press(1, sw);
        n_checks++;
        if (calc_op !== m_op) begin
            n_fail++;
            $display("FAIL held_at_reset calc_op=%0d required=%0d", calc_op, m_op);
        end
        $display("txn held_at_reset calc_op=%0d", calc_op);
    endtask

    task automatic test_random();
        int k;
        logic [7:0] s;
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(0, 2));
            s = 8'($urandom);
            sw = s;
            press_key(k);
            model_press(k, s);
            n_checks++;
            if ({calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy}
                !== {m_op, m_a, m_b, m_res, m_ovf, m_valid, 1'b0}) begin
                n_fail++;
                $display("FAIL random_%0d key=%0d sw=%h got=%h required=%h", i, k, s,
                         {calc_op, calc_a, calc_b, res, res_ovf, res_valid, busy},
                         {m_op, m_a, m_b, m_res, m_ovf, m_valid, 1'b0});
            end
            $display("txn random %0d key=%0d sw=%h op=%0d res=%h ovf=%b valid=%b",
                     i, k, s, calc_op, res, res_ovf, res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_compute();
        test_op_wrap();
        test_overflow();
        test_simultaneous();
        test_reset_mid_op();
        test_held_at_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
